bitty_core_param: RTL and testbench

//  Parametrised multi-cycle Bitty core: register file, S/C staging regs, ALU, operand mux, FSM control.

---
 rtl/bitty_core_param.sv | 157 +++++++++++++++
 tb/tb_bitty_core_param.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_core_param.sv
// Parametrised multi-cycle Bitty core: register file, S/C staging registers, ALU and
// a four-state control FSM behind a valid/ready instruction handshake.
module bitty_core_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS),
  localparam int INST_W  = 2*REG_AW + 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] instruction,
  output logic              done,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int IMM_W = REG_AW + 5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] c_q;
  logic [INST_W-1:0] inst_q;
  logic              done_q;
  logic              err_q;

  logic [REG_AW-1:0] rx;
  logic [REG_AW-1:0] ry;
  logic [IMM_W-1:0]  imm;
  logic [2:0]        op;
  logic [1:0]        fmt;
  logic              illegal;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] alu_y;

  logic accept;
  logic load_s;
  logic exec_en;
  logic wb_en;

  assign rx      = inst_q[INST_W-1 -: REG_AW];
  assign ry      = inst_q[INST_W-1-REG_AW -: REG_AW];
  assign imm     = inst_q[INST_W-1-REG_AW:5];
  assign op      = inst_q[4:2];
  assign fmt     = inst_q[1:0];
  assign illegal = fmt[1];

  // Immediate is zero-extended; illegal formats still compute but never write back.
  assign b_val = (fmt == 2'b01) ? DATA_W'(imm) : regs[ry];

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD: alu_y = s_q + b_val;
      OP_SUB: alu_y = s_q - b_val;
      OP_AND: alu_y = s_q & b_val;
      OP_OR:  alu_y = s_q | b_val;
      OP_XOR: alu_y = s_q ^ b_val;
      OP_SHL: alu_y = s_q << b_val[SH_W-1:0];
      OP_SHR: alu_y = s_q >> b_val[SH_W-1:0];
      OP_CMP: begin
        if (s_q == b_val)     alu_y = '0;
        else if (s_q > b_val) alu_y = DATA_W'(1);
        else                  alu_y = DATA_W'(2);
      end
      default: alu_y = '0;
    endcase
  end

  // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready.
  // inst_ready is high only in IDLE with reset low; instruction is don't-care otherwise.
  always_comb begin
    state_next = state;
    inst_ready = 1'b0;
    accept     = 1'b0;
    load_s     = 1'b0;
    exec_en    = 1'b0;
    wb_en      = 1'b0;
    case (state)
      IDLE: begin
        inst_ready = !reset;
        if (inst_valid && !reset) begin
          accept     = 1'b1;
          state_next = LOAD_S;
        end
      end
      LOAD_S: begin
        load_s     = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        exec_en    = 1'b1;
        state_next = WB;
      end
      WB: begin
        wb_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Reset clears everything, so an aborted instruction never reaches writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      s_q    <= '0;
      c_q    <= '0;
      inst_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept)  inst_q <= instruction;
      if (load_s)  s_q    <= regs[rx];
      if (exec_en) c_q    <= alu_y;
      if (wb_en) begin
        if (!illegal) regs[rx] <= c_q;
        done_q <= 1'b1;
        err_q  <= illegal;
      end
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_bitty_core_param.sv
// Directed bench for bitty_core_param: default 16-bit/8-reg instance plus a 32-bit/16-reg one.
module tb_bitty_core_param;

  logic clk;
  logic reset;

  logic        a_inst_valid;
  logic        a_inst_ready;
  logic [15:0] a_instruction;
  logic        a_done;
  logic        a_err;
  logic [2:0]  a_dbg_addr;
  logic [15:0] a_dbg_data;

  logic        b_inst_valid;
  logic        b_inst_ready;
  logic [17:0] b_instruction;
  logic        b_done;
  logic        b_err;
  logic [3:0]  b_dbg_addr;
  logic [31:0] b_dbg_data;

  int total;
  int bad;

  bitty_core_param dut_a (
    .clk(clk), .reset(reset),
    .inst_valid(a_inst_valid), .inst_ready(a_inst_ready), .instruction(a_instruction),
    .done(a_done), .err(a_err), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
  );

  bitty_core_param #(.DATA_W(32), .NUM_REGS(16)) dut_b (
    .clk(clk), .reset(reset),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .instruction(b_instruction),
    .done(b_done), .err(b_err), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // instruction encoders
  function automatic logic [15:0] ea_ri(int rx, int imm, int op, int fmt);
    return {3'(rx), 8'(imm), 3'(op), 2'(fmt)};
  endfunction
  function automatic logic [15:0] ea_rr(int rx, int ry, int op);
    return {3'(rx), 3'(ry), 5'd0, 3'(op), 2'b00};
  endfunction
  function automatic logic [17:0] eb_ri(int rx, int imm, int op, int fmt);
    return {4'(rx), 9'(imm), 3'(op), 2'(fmt)};
  endfunction
  function automatic logic [17:0] eb_rr(int rx, int ry, int op);
    return {4'(rx), 4'(ry), 5'd0, 3'(op), 2'b00};
  endfunction

  // driver tasks: issue one instruction, check latency and retire flags
  task automatic issue_a(input logic [15:0] ins, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_inst_ready && n < 10) begin @(negedge clk); n++; end
    total++;
    if (a_inst_ready !== 1'b1) begin
      bad++; $display("FAIL a_ready_wait: inst_ready=%b want 1", a_inst_ready);
    end
    a_inst_valid  = 1'b1;
    a_instruction = ins;
    @(posedge clk);
    #1;
    a_inst_valid  = 1'b0;
    a_instruction = 16'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({a_done, a_inst_ready} !== 2'b00) begin
        bad++; $display("FAIL a_busy cyc%0d: done,ready=%b want 00", k, {a_done, a_inst_ready});
      end
    end
    @(negedge clk);
    total++;
    if ({a_done, a_err, a_inst_ready} !== {1'b1, exp_err, 1'b1}) begin
      bad++; $display("FAIL a_retire %h: done,err,ready=%b want %b", ins,
                      {a_done, a_err, a_inst_ready}, {1'b1, exp_err, 1'b1});
    end
  endtask

  task automatic issue_b(input logic [17:0] ins, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (!b_inst_ready && n < 10) begin @(negedge clk); n++; end
    b_inst_valid  = 1'b1;
    b_instruction = ins;
    @(posedge clk);
    #1;
    b_inst_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_done && n < 8);
    total++;
    if ({b_done, b_err, n} !== {1'b1, exp_err, 32'd4}) begin
      bad++; $display("FAIL b_retire %h: done=%b err=%b after %0d cycles want 1 %b 4",
                      ins, b_done, b_err, n, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_inst_valid = 1'b0; a_instruction = '0; a_dbg_addr = '0;
    b_inst_valid = 1'b0; b_instruction = '0; b_dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({a_inst_ready, a_done, a_err, b_inst_ready} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: ready,done,err,b_ready=%b want 0000",
                      {a_inst_ready, a_done, a_err, b_inst_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({a_inst_ready, b_inst_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_ready: %b want 11", {a_inst_ready, b_inst_ready});
    end
    for (int r = 0; r < 8; r++) begin
      a_dbg_addr = 3'(r); #1;
      total++;
      if (a_dbg_data !== 16'h0000) begin
        bad++; $display("FAIL reset_a_R%0d: got %h want 0000", r, a_dbg_data);
      end
    end
    for (int r = 0; r < 16; r++) begin
      b_dbg_addr = 4'(r); #1;
      total++;
      if (b_dbg_data !== 32'h0) begin
        bad++; $display("FAIL reset_b_R%0d: got %h want 0", r, b_dbg_data);
      end
    end
  endtask

  task automatic test_add_imm();
    a_dbg_addr = 3'd0;
    @(negedge clk);
    a_inst_valid  = 1'b1;
    a_instruction = ea_ri(0, 5, 0, 1);
    @(posedge clk);
    #1;
    a_inst_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({a_done, a_dbg_data} !== {1'b0, 16'h0000}) begin
        bad++; $display("FAIL add_imm_early cyc%0d: done=%b R0=%h want 0 0000", k, a_done, a_dbg_data);
      end
    end
    @(negedge clk);
    total++;
    if ({a_done, a_err, a_dbg_data} !== {1'b1, 1'b0, 16'h0005}) begin
      bad++; $display("FAIL add_imm_retire: done=%b err=%b R0=%h want 1 0 0005", a_done, a_err, a_dbg_data);
    end
    @(negedge clk);
    total++;
    if ({a_done, a_err} !== 2'b00) begin
      bad++; $display("FAIL add_imm_pulse: done,err=%b want 00", {a_done, a_err});
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_v [3];
    logic [15:0] ins_v [3];
    int          reg_v [3];
    ins_v = '{ea_ri(1, 1, 1, 1), ea_ri(1, 1, 0, 1), ea_ri(2, 1, 1, 1)};
    exp_v = '{16'hFFFF, 16'h0000, 16'hFFFF};
    reg_v = '{1, 1, 2};
    for (int i = 0; i < 3; i++) begin
      issue_a(ins_v[i], 1'b0);
      a_dbg_addr = 3'(reg_v[i]); #1;
      total++;
      if (a_dbg_data !== exp_v[i]) begin
        bad++; $display("FAIL wrap%0d R%0d: got %h want %h", i, reg_v[i], a_dbg_data, exp_v[i]);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] ins_v [16];
    logic [15:0] exp_v [16];
    int          reg_v [16];
    ins_v = '{ea_ri(3, 4, 0, 1), ea_ri(4, 9, 0, 1), ea_rr(3, 4, 7), ea_rr(4, 4, 7),
              ea_ri(4, 17, 5, 1), ea_ri(5, 3, 0, 1), ea_ri(5, 17, 5, 1), ea_ri(2, 4, 6, 1),
              ea_ri(6, 8'hF0, 0, 1), ea_ri(6, 8'h3C, 2, 1), ea_ri(6, 8'h0F, 3, 1), ea_ri(6, 8'hFF, 4, 1),
              ea_rr(6, 5, 7), ea_rr(2, 5, 1), ea_ri(7, 8'hFF, 0, 1), ea_rr(7, 7, 0)};
    exp_v = '{16'h0004, 16'h0009, 16'h0002, 16'h0000,
              16'h0000, 16'h0003, 16'h0006, 16'h0FFF,
              16'h00F0, 16'h0030, 16'h003F, 16'h00C0,
              16'h0001, 16'h0FF9, 16'h00FF, 16'h01FE};
    reg_v = '{3, 4, 3, 4, 4, 5, 5, 2, 6, 6, 6, 6, 6, 2, 7, 7};
    for (int i = 0; i < 16; i++) begin
      issue_a(ins_v[i], 1'b0);
      a_dbg_addr = 3'(reg_v[i]); #1;
      total++;
      if (a_dbg_data !== exp_v[i]) begin
        bad++; $display("FAIL alu%0d R%0d: got %h want %h", i, reg_v[i], a_dbg_data, exp_v[i]);
      end
    end
    issue_a(ea_ri(7, 8'h13, 5, 1), 1'b0);
    a_dbg_addr = 3'd7; #1;
    total++;
    if (a_dbg_data !== 16'h0FF0) begin
      bad++; $display("FAIL alu_shl_mod R7: got %h want 0ff0", a_dbg_data);
    end
  endtask

  task automatic test_illegal();
    issue_a(ea_ri(0, 7, 0, 2), 1'b1);
    @(negedge clk);
    total++;
    if ({a_done, a_err} !== 2'b00) begin
      bad++; $display("FAIL illegal_pulse: done,err=%b want 00", {a_done, a_err});
    end
    a_dbg_addr = 3'd0; #1;
    total++;
    if (a_dbg_data !== 16'h0005) begin
      bad++; $display("FAIL illegal_fmt10 R0: got %h want 0005", a_dbg_data);
    end
    issue_a(ea_ri(2, 1, 1, 3), 1'b1);
    a_dbg_addr = 3'd2; #1;
    total++;
    if (a_dbg_data !== 16'h0FF9) begin
      bad++; $display("FAIL illegal_fmt11 R2: got %h want 0ff9", a_dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int last;
    int n;
    idx  = 0;
    last = 0;
    a_inst_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
      @(negedge clk);
      a_instruction = ea_ri(0, 1, 0, 1);
      if (a_inst_ready) begin
        if (idx > 0) begin
          total++;
          if ({a_done, 32'(cyc - last)} !== {1'b1, 32'd4}) begin
            bad++; $display("FAIL b2b_accept%0d: done=%b gap=%0d want 1 4", idx, a_done, cyc - last);
          end
        end
        last = cyc;
        idx++;
      end
    end
    total++;
    if (idx !== 3) begin
      bad++; $display("FAIL b2b_count: accepted %0d want 3", idx);
    end
    @(negedge clk);
    a_inst_valid = 1'b0;
    n = 0;
    while (!a_done && n < 8) begin @(negedge clk); n++; end
    a_dbg_addr = 3'd0; #1;
    total++;
    if ({a_done, a_dbg_data} !== {1'b1, 16'h0008}) begin
      bad++; $display("FAIL b2b_result: done=%b R0=%h want 1 0008", a_done, a_dbg_data);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    a_inst_valid  = 1'b1;
    a_instruction = ea_ri(1, 9, 0, 1);
    @(posedge clk);
    #1;
    a_inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (a_inst_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ready_hi: got %b want 0", a_inst_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (a_inst_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ready_after: got %b want 1", a_inst_ready);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (a_done) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rst_mid_done: pulses=%0d want 0", seen);
    end
    for (int r = 0; r < 8; r++) begin
      a_dbg_addr = 3'(r); #1;
      total++;
      if (a_dbg_data !== 16'h0000) begin
        bad++; $display("FAIL rst_mid_R%0d: got %h want 0000", r, a_dbg_data);
      end
    end
  endtask

  task automatic test_wide();
    logic [17:0] ins_v [11];
    logic [31:0] exp_v [11];
    int          reg_v [11];
    ins_v = '{eb_ri(0, 5, 0, 1), eb_ri(1, 1, 1, 1), eb_ri(1, 1, 0, 1), eb_ri(15, 9'h1FF, 0, 1),
              eb_ri(3, 4, 0, 1), eb_ri(4, 9, 0, 1), eb_rr(3, 4, 7), eb_rr(4, 4, 7),
              eb_ri(0, 9'h1FF, 5, 1), eb_ri(5, 3, 0, 1), eb_ri(5, 33, 5, 1)};
    exp_v = '{32'h5, 32'hFFFF_FFFF, 32'h0, 32'h1FF,
              32'h4, 32'h9, 32'h2, 32'h0,
              32'h8000_0000, 32'h3, 32'h6};
    reg_v = '{0, 1, 1, 15, 3, 4, 3, 4, 0, 5, 5};
    for (int i = 0; i < 11; i++) begin
      issue_b(ins_v[i], 1'b0);
      b_dbg_addr = 4'(reg_v[i]); #1;
      total++;
      if (b_dbg_data !== exp_v[i]) begin
        bad++; $display("FAIL wide%0d R%0d: got %h want %h", i, reg_v[i], b_dbg_data, exp_v[i]);
      end
    end
    issue_b(eb_ri(15, 1, 0, 2), 1'b1);
    b_dbg_addr = 4'd15; #1;
    total++;
    if (b_dbg_data !== 32'h1FF) begin
      bad++; $display("FAIL wide_illegal R15: got %h want 000001ff", b_dbg_data);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_imm();
    test_wrap();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
